// File: rtl/sigmoid_pkg.sv
// Purpose: shared constants and FSM state type for the inverse-sigmoid (logit) block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sigmoid_pkg;
    localparam int FBIT    = 10;     // fractional bits of yin/xout
    localparam int ONE     = 1024;   // 1.0 in Q.10
    localparam int QBIT    = 20;     // quotient bits produced by the divider
    localparam int LATENCY = 22;     // capture edge to dv_out, in clocks
    localparam int YBIT    = 11;     // width of the Q1.10 probability input

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        FIN  = 2'd2
    } state_t;
endpackage

// File: rtl/sigmoid_inv_if.sv
// Purpose: request/result bundle for sigmoid_inv (dv_in/yin in, dv_out/xout/busy out).
// Latency: n/a (wires only).
// Backpressure: none; starts arriving while busy are dropped by the slave.
interface sigmoid_inv_if
    import sigmoid_pkg::*;
#(
    parameter int OBIT = 32
) ();
    logic            dv_in;
    logic [YBIT-1:0] yin;
    logic            dv_out;
    logic [OBIT-1:0] xout;
    logic            busy;

    modport master (output dv_in, yin, input dv_out, xout, busy);
    modport slave  (input dv_in, yin, output dv_out, xout, busy);
endinterface

// File: rtl/udiv_restoring.sv
// Purpose: serial unsigned restoring divider, one quotient bit per clock, MSB first.
// Latency: operands load on the start edge, NW iteration edges follow, done pulses after the last.
// Backpressure: none; start is assumed only when idle, den must stay stable while running.
// Ports: start/num/den in, done (1-clock pulse) and quo out.
module udiv_restoring #(
    parameter int NW = 20,   // numerator / quotient width
    parameter int DW = 11    // divisor width
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [NW-1:0] num,
    input  logic [DW-1:0] den,
    output logic          done,
    output logic [NW-1:0] quo
);
    localparam int CW = $clog2(NW);

    logic [NW-1:0] num_q;
    logic [DW-1:0] rem_q;
    logic [NW-1:0] quo_q;
    logic [CW-1:0] cnt_q;
    logic          run_q;
    logic          done_q;

    // Partial remainder shifted left by one with the next numerator bit.
    // The remainder is always below den, so DW+1 bits hold the trial value.
    logic [DW:0]   trial;
    logic          ge;
    logic [DW-1:0] rem_d;

    always_comb begin
        trial = {rem_q, num_q[NW-1]};
        ge    = (trial >= {1'b0, den});
        rem_d = ge ? DW'(trial - {1'b0, den}) : trial[DW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                num_q <= num;
                rem_q <= '0;
                quo_q <= '0;
                cnt_q <= '0;
                run_q <= 1'b1;
            end else if (run_q) begin
                num_q <= {num_q[NW-2:0], 1'b0};
                rem_q <= rem_d;
                quo_q <= {quo_q[NW-2:0], ge};
                cnt_q <= cnt_q + 1'b1;
                if (cnt_q == CW'(NW - 1)) begin
                    run_q  <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign done = done_q;
    assign quo  = quo_q;
endmodule

// File: rtl/sigmoid_inv.sv
// Purpose: logit of a Q1.10 probability: xout = sign(t)*floor(|t|*1024/(1024-|t|)), t = 2*yin-1024.
// Latency: fixed 22 clocks from the capturing edge to the one-clock dv_out pulse, for every yin.
// Backpressure: none; start edges seen while busy are dropped, not queued.
// Ports: clk, rst_n (async active-low), bus (slave): dv_in, yin in; dv_out, xout, busy out.
module sigmoid_inv
    import sigmoid_pkg::*;
#(
    parameter int OBIT = 32,
    parameter int FBIT = sigmoid_pkg::FBIT
) (
    input  logic          clk,
    input  logic          rst_n,
    sigmoid_inv_if.slave  bus
);
    // Working width for the magnitude: wide enough for the quotient and for OBIT.
    localparam int W  = (OBIT > QBIT + 1) ? OBIT : QBIT + 1;
    localparam int NB = QBIT - FBIT;   // integer bits of the dividend fed to the divider

    state_t state_q, state_d;

    logic              bfr_dv;
    logic              start;
    logic signed [12:0] t;
    logic [11:0]       abs_t;

    logic              neg_q, sat_pos_q, sat_neg_q;
    logic [NB-1:0]     dividend_q;
    logic [10:0]       divisor_q;
    logic              div_go, div_done;
    logic [QBIT-1:0]   div_quo;

    logic [W-1:0]      mag, mag_lim, res_w;
    logic [OBIT-1:0]   x_next, xout_q;

    assign start = bus.dv_in & ~bfr_dv;

    always_comb begin
        t     = $signed({1'b0, bus.yin, 1'b0}) - 13'sd1024;
        abs_t = t[12] ? 12'(-t) : 12'(t);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = DIV;
            DIV:     if (div_done) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Result shaping: clamp magnitude for narrow OBIT, then apply the sign.
    // Saturated inputs (yin==0, yin>=1.0) override the divider result.
    always_comb begin
        mag     = W'(div_quo);
        mag_lim = (W'(1) << (OBIT - 1)) - W'(1);
        if (mag > mag_lim)
            mag = mag_lim;
        res_w   = neg_q ? (-mag) : mag;
        if (sat_neg_q)
            x_next = {1'b1, {(OBIT-1){1'b0}}};
        else if (sat_pos_q)
            x_next = {1'b0, {(OBIT-1){1'b1}}};
        else
            x_next = res_w[OBIT-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bfr_dv     <= 1'b1;   // dv_in held high through reset must not look like an edge
            neg_q      <= 1'b0;
            sat_pos_q  <= 1'b0;
            sat_neg_q  <= 1'b0;
            dividend_q <= '0;
            divisor_q  <= '0;
            div_go     <= 1'b0;
            xout_q     <= '0;
        end else begin
            bfr_dv  <= bus.dv_in;
            state_q <= state_d;
            div_go  <= (state_q == IDLE) && start;
            if ((state_q == IDLE) && start) begin
                neg_q      <= t[12];
                sat_neg_q  <= (bus.yin == '0);
                sat_pos_q  <= bus.yin[10];
                dividend_q <= abs_t[NB-1:0];
                divisor_q  <= 11'(12'd1024 - abs_t);
            end
            // xout is loaded as FIN is entered so it is valid in the dv_out cycle.
            if ((state_q == DIV) && div_done)
                xout_q <= x_next;
        end
    end

    // The divider starts one clock after capture from the registered operands;
    // with its trailing done pulse this gives the fixed 22-clock latency.
    udiv_restoring #(.NW(QBIT), .DW(11)) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .start (div_go),
        .num   ({dividend_q, {FBIT{1'b0}}}),
        .den   (divisor_q),
        .done  (div_done),
        .quo   (div_quo)
    );

    assign bus.dv_out = (state_q == FIN);
    assign bus.busy   = (state_q != IDLE);
    assign bus.xout   = xout_q;
endmodule

// File: tb/tb_sigmoid_inv.sv
// Purpose: self-checking bench for sigmoid_inv: vector table, corner sequences, full yin sweep.
// Latency: expects dv_out exactly 22 clocks after each capturing edge.
// Backpressure: starts are only issued when the DUT is idle, except the deliberately ignored one.
module tb_sigmoid_inv;
    import sigmoid_pkg::*;

    logic clk;
    logic rst_n;

    sigmoid_inv_if #(.OBIT(32)) bus ();

    sigmoid_inv #(.OBIT(32), .FBIT(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct { logic [31:0] exp; int cap; } sb_t;
    sb_t sb[$];
    sb_t mon_e;

    typedef struct { logic [10:0] yin; logic [31:0] exp; } vec_t;
    vec_t vec[9];

    int   total  = 0;
    int   passed = 0;
    int   dv_cnt = 0;
    logic prev_dv = 1'b0;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        total = total + 1;
        if (ok) passed = passed + 1;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    endtask

    function automatic logic [31:0] ref_x(input int y);
        longint tt, a, q;
        if (y == 0) return 32'h8000_0000;
        if (y >= 1024) return 32'h7FFF_FFFF;
        tt = 2 * y - 1024;
        a  = (tt < 0) ? -tt : tt;
        q  = (a * 1024) / (1024 - a);
        return (tt < 0) ? 32'(-q) : 32'(q);
    endfunction

    // Scoreboard: every dv_out pops one expectation and checks value, latency and busy.
    always @(negedge clk) begin
        if (prev_dv)
            check(bus.dv_out == 1'b0, "dv_out_width", 32'(bus.dv_out), 32'd0);
        prev_dv = bus.dv_out;
        if (bus.dv_out) begin
            dv_cnt = dv_cnt + 1;
            if (sb.size() == 0) begin
                check(1'b0, "unexpected_dv_out", bus.xout, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check(bus.xout === mon_e.exp, "xout", bus.xout, mon_e.exp);
                check((cyc - mon_e.cap) == LATENCY, "latency", 32'(cyc - mon_e.cap), 32'(LATENCY));
                check(bus.busy === 1'b1, "busy_at_dv_out", 32'(bus.busy), 32'd1);
            end
        end
    end

    task automatic start_conv(input logic [10:0] y, input logic [31:0] e);
        sb_t s;
        @(negedge clk);
        bus.yin   = y;
        bus.dv_in = 1'b1;
        s.exp = e;
        s.cap = cyc + 1;
        sb.push_back(s);
        @(negedge clk);
        bus.dv_in = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check(1'b0, "timeout_dv_out", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    logic [10:0] order [2048];

    initial begin
        int d0;
        int n;
        logic [10:0] tmp;

        vec[0] = '{11'd768,  32'd1024};
        vec[1] = '{11'd256,  32'hFFFF_FC00};
        vec[2] = '{11'd512,  32'd0};
        vec[3] = '{11'd853,  32'd2042};
        vec[4] = '{11'd1023, 32'd523264};
        vec[5] = '{11'd1,    32'hFFF8_0400};
        vec[6] = '{11'd0,    32'h8000_0000};
        vec[7] = '{11'd1024, 32'h7FFF_FFFF};
        vec[8] = '{11'd2047, 32'h7FFF_FFFF};

        // Reset state, with dv_in already high so release must not start anything.
        rst_n     = 1'b0;
        bus.dv_in = 1'b1;
        bus.yin   = 11'd768;
        repeat (3) @(negedge clk);
        check(bus.xout == 32'd0, "reset_xout", bus.xout, 32'd0);
        check(bus.dv_out == 1'b0, "reset_dv_out", 32'(bus.dv_out), 32'd0);
        check(bus.busy == 1'b0, "reset_busy", 32'(bus.busy), 32'd0);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check(dv_cnt == 0, "held_dv_in_no_start", 32'(dv_cnt), 32'd0);
        check(bus.busy == 1'b0, "held_dv_in_idle", 32'(bus.busy), 32'd0);
        bus.dv_in = 1'b0;
        @(negedge clk);

        // Directed vector table.
        for (int i = 0; i < 9; i++) begin
            start_conv(vec[i].yin, vec[i].exp);
            check(bus.busy == 1'b1, "busy_after_capture", 32'(bus.busy), 32'd1);
            wait_idle();
        end

        // A second edge five clocks into a conversion is dropped.
        d0 = dv_cnt;
        start_conv(11'd768, 32'd1024);
        repeat (4) @(negedge clk);
        bus.yin   = 11'd256;
        bus.dv_in = 1'b1;
        @(negedge clk);
        bus.dv_in = 1'b0;
        wait_idle();
        repeat (30) @(negedge clk);
        check(dv_cnt - d0 == 1, "ignored_start_count", 32'(dv_cnt - d0), 32'd1);

        // Reset ten clocks into a conversion, dv_in held high through release.
        d0 = dv_cnt;
        @(negedge clk);
        bus.yin   = 11'd768;
        bus.dv_in = 1'b1;
        repeat (10) @(negedge clk);
        check(bus.busy == 1'b1, "busy_mid_conv", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check(bus.xout == 32'd0, "abort_xout", bus.xout, 32'd0);
        check(bus.busy == 1'b0, "abort_busy", 32'(bus.busy), 32'd0);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check(dv_cnt == d0, "abort_no_dv_out", 32'(dv_cnt - d0), 32'd0);
        check(bus.xout == 32'd0, "abort_xout_hold", bus.xout, 32'd0);
        bus.dv_in = 1'b0;
        @(negedge clk);
        start_conv(11'd768, 32'd1024);
        wait_idle();

        // Shuffled sweep of every yin, each start in the clock after the previous dv_out.
        for (int i = 0; i < 2048; i++) order[i] = 11'(i);
        for (int i = 2047; i > 0; i--) begin
            int j;
            j        = $urandom_range(i, 0);
            tmp      = order[i];
            order[i] = order[j];
            order[j] = tmp;
        end
        d0 = dv_cnt;
        for (int i = 0; i < 2048; i++) begin
            start_conv(order[i], ref_x(int'(order[i])));
            n = 0;
            while (!bus.dv_out && n < 40) begin
                @(negedge clk);
                n++;
            end
            if (!bus.dv_out) begin
                check(1'b0, "sweep_timeout", 32'(order[i]), 32'd0);
                sb.delete();
            end
        end
        wait_idle();
        check(dv_cnt - d0 == 2048, "sweep_dv_out_count", 32'(dv_cnt - d0), 32'd2048);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
